// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared states, operand selects and control word for poly_eval
package poly_pkg;

  // FSM states; the encodings are shown on the board LEDs, so they are fixed
  typedef enum logic [3:0] {
    LOAD_A      = 4'd0,
    LOAD_A_WAIT = 4'd1,
    LOAD_B      = 4'd2,
    LOAD_B_WAIT = 4'd3,
    LOAD_C      = 4'd4,
    LOAD_C_WAIT = 4'd5,
    LOAD_X      = 4'd6,
    LOAD_X_WAIT = 4'd7,
    C0          = 4'd8,
    C1          = 4'd9,
    C2          = 4'd10,
    C3          = 4'd11,
    C4          = 4'd12,
    DONE        = 4'd13,
    DONE_WAIT   = 4'd14
  } state_e;

  // Multiplier operand A select (2W-wide side)
  localparam logic [1:0] MA_A  = 2'd0;
  localparam logic [1:0] MA_B  = 2'd1;
  localparam logic [1:0] MA_RA = 2'd2;

  // Multiplier operand B select (W-wide side); x is the only source
  localparam logic MB_X = 1'b0;

  // Adder operand selects
  localparam logic AA_RA = 1'b0;
  localparam logic AB_RB = 1'b0;
  localparam logic AB_C  = 1'b1;

  // Source of the value written into RA
  localparam logic RA_SRC_MUL = 1'b0;
  localparam logic RA_SRC_ADD = 1'b1;

  // Control word from the FSM to the datapath: selects plus one write
  // enable per destination register
  typedef struct packed {
    logic [1:0] ma_sel;
    logic       mb_sel;
    logic       aa_sel;
    logic       ab_sel;
    logic       ra_src;
    logic       we_a;
    logic       we_b;
    logic       we_c;
    logic       we_x;
    logic       we_ra;
    logic       we_rb;
    logic       we_res;
  } ctrl_t;

  // Control word with every write enable off
  localparam ctrl_t CTRL_IDLE = '{
    ma_sel: MA_A,
    mb_sel: MB_X,
    aa_sel: AA_RA,
    ab_sel: AB_RB,
    ra_src: RA_SRC_MUL,
    we_a:   1'b0,
    we_b:   1'b0,
    we_c:   1'b0,
    we_x:   1'b0,
    we_ra:  1'b0,
    we_rb:  1'b0,
    we_res: 1'b0
  };

  // True in the five compute states
  function automatic logic is_compute(input state_e s);
    return (s == C0) || (s == C1) || (s == C2) || (s == C3) || (s == C4);
  endfunction

endpackage

// File: rtl/poly_datapath.sv
// rtl/poly_datapath.sv - operand/scratch/result registers with one shared multiplier and adder
module poly_datapath
  import poly_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  ctrl_t          ctrl,
  input  logic [W-1:0]   data_in,
  output logic [3*W-1:0] result
);

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic [W-1:0]   x_q, x_d;
  logic [3*W-1:0] ra_q, ra_d;
  logic [3*W-1:0] rb_q, rb_d;
  logic [3*W-1:0] res_q, res_d;

  logic [2*W-1:0] mul_a;
  logic [W-1:0]   mul_b;
  logic [3*W-1:0] mul_p;
  logic [3*W-1:0] add_a;
  logic [3*W-1:0] add_b;
  logic [3*W-1:0] add_s;

  // Operand muxes; RA only ever holds A*x (< 2^2W) when it feeds the
  // multiplier, so its low 2W bits are the whole value there
  always_comb begin
    mul_a = '0;
    case (ctrl.ma_sel)
      MA_A:    mul_a = {{W{1'b0}}, a_q};
      MA_B:    mul_a = {{W{1'b0}}, b_q};
      MA_RA:   mul_a = ra_q[2*W-1:0];
      default: mul_a = '0;
    endcase
    mul_b = (ctrl.mb_sel == MB_X) ? x_q : '0;
    add_a = (ctrl.aa_sel == AA_RA) ? ra_q : '0;
    add_b = (ctrl.ab_sel == AB_C) ? {{(2*W){1'b0}}, c_q} : rb_q;
  end

  // 2W x W unsigned multiply and 3W add; neither can exceed 3W bits
  assign mul_p = {{W{1'b0}}, mul_a} * {{(2*W){1'b0}}, mul_b};
  assign add_s = add_a + add_b;

  // Next-state for every register, gated by its write enable
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    x_d   = x_q;
    ra_d  = ra_q;
    rb_d  = rb_q;
    res_d = res_q;
    if (ctrl.we_a)   a_d   = data_in;
    if (ctrl.we_b)   b_d   = data_in;
    if (ctrl.we_c)   c_d   = data_in;
    if (ctrl.we_x)   x_d   = data_in;
    if (ctrl.we_ra)  ra_d  = (ctrl.ra_src == RA_SRC_ADD) ? add_s : mul_p;
    if (ctrl.we_rb)  rb_d  = mul_p;
    if (ctrl.we_res) res_d = add_s;
  end

  // Register bank; reset clears everything so no partial result survives
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      x_q   <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      x_q   <= x_d;
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/poly_eval.sv
// rtl/poly_eval.sv - Go-handshake operand loader and compute scheduler for A*x^2 + B*x + C
module poly_eval
  import poly_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Go,
  input  logic [W-1:0]   DataIn,
  output logic [3*W-1:0] Result,
  output logic           Done,
  output logic           Busy,
  output logic [3:0]     CurState
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // State register; reset has priority over any Go activity
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus datapath control. Each LOAD state captures once and
  // then parks in its WAIT state until Go drops, so a held Go cannot
  // load the same value into two operands.
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    case (state_q)
      LOAD_A: begin
        if (Go) begin
          ctrl.we_a = 1'b1;
          state_d   = LOAD_A_WAIT;
        end
      end
      LOAD_A_WAIT: if (!Go) state_d = LOAD_B;
      LOAD_B: begin
        if (Go) begin
          ctrl.we_b = 1'b1;
          state_d   = LOAD_B_WAIT;
        end
      end
      LOAD_B_WAIT: if (!Go) state_d = LOAD_C;
      LOAD_C: begin
        if (Go) begin
          ctrl.we_c = 1'b1;
          state_d   = LOAD_C_WAIT;
        end
      end
      LOAD_C_WAIT: if (!Go) state_d = LOAD_X;
      LOAD_X: begin
        if (Go) begin
          ctrl.we_x = 1'b1;
          state_d   = LOAD_X_WAIT;
        end
      end
      LOAD_X_WAIT: if (!Go) state_d = C0;
      C0: begin
        ctrl.ma_sel = MA_A;
        ctrl.mb_sel = MB_X;
        ctrl.ra_src = RA_SRC_MUL;
        ctrl.we_ra  = 1'b1;
        state_d     = C1;
      end
      C1: begin
        ctrl.ma_sel = MA_RA;
        ctrl.mb_sel = MB_X;
        ctrl.ra_src = RA_SRC_MUL;
        ctrl.we_ra  = 1'b1;
        state_d     = C2;
      end
      C2: begin
        ctrl.ma_sel = MA_B;
        ctrl.mb_sel = MB_X;
        ctrl.we_rb  = 1'b1;
        state_d     = C3;
      end
      C3: begin
        ctrl.aa_sel = AA_RA;
        ctrl.ab_sel = AB_RB;
        ctrl.ra_src = RA_SRC_ADD;
        ctrl.we_ra  = 1'b1;
        state_d     = C4;
      end
      C4: begin
        ctrl.aa_sel = AA_RA;
        ctrl.ab_sel = AB_C;
        ctrl.we_res = 1'b1;
        state_d     = DONE;
      end
      DONE:      if (Go) state_d = DONE_WAIT;
      DONE_WAIT: if (!Go) state_d = LOAD_A;
      default:   state_d = LOAD_A;
    endcase
  end

  poly_datapath #(
    .W (W)
  ) u_datapath (
    .clk     (Clock),
    .rst     (Reset),
    .ctrl    (ctrl),
    .data_in (DataIn),
    .result  (Result)
  );

  // Status outputs decode registered state only
  assign CurState = state_q;
  assign Done     = (state_q == DONE);
  assign Busy     = is_compute(state_q);

endmodule

// File: tb/tb_poly_eval.sv
// tb/tb_poly_eval.sv - scoreboard bench for poly_eval with directed operand sets
module tb_poly_eval;

  localparam int W = 8;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Go = 1'b0;
  logic [W-1:0]   DataIn = '0;
  logic [3*W-1:0] Result;
  logic           Done;
  logic           Busy;
  logic [3:0]     CurState;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb[$];
  chk_t        chk_q[$];
  bit          end_req = 1'b0;

  always #5 Clock = ~Clock;

  poly_eval #(
    .W (W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Go       (Go),
    .DataIn   (DataIn),
    .Result   (Result),
    .Done     (Done),
    .Busy     (Busy),
    .CurState (CurState)
  );

  task automatic post(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = nm;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_op(input logic [W-1:0] v, input int hi, input int lo);
    DataIn = v;
    Go     = 1'b1;
    repeat (hi) tick();
    Go = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 60) begin
      tick();
      n++;
    end
    if (!Done) post("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_state(input logic [3:0] s);
    int n = 0;
    while (CurState != s && n < 60) begin
      tick();
      n++;
    end
    post("reach_state", {60'd0, CurState}, {60'd0, s});
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                     input logic [W-1:0] x, input logic [63:0] exp, input logic [63:0] held);
    sb.push_back(exp);
    load_op(a, 3, 2);
    post("result_held_during_load", {40'd0, Result}, held);
    load_op(b, 3, 2);
    load_op(c, 3, 2);
    load_op(x, 3, 2);
    wait_done();
  endtask

  task automatic ack_done();
    Go = 1'b1;
    tick();
    tick();
    Go = 1'b0;
    tick();
  endtask

  // Stimulus
  initial begin
    tick();
    tick();
    post("reset_state", {60'd0, CurState}, 64'd0);
    post("reset_result", {40'd0, Result}, 64'd0);
    post("reset_done", {63'd0, Done}, 64'd0);
    post("reset_busy", {63'd0, Busy}, 64'd0);
    Reset = 1'b0;
    tick();

    run(8'd1, 8'd2, 8'd3, 8'd4, 64'd27, 64'd0);
    post("in_done_state", {60'd0, CurState}, 64'd13);
    Go = 1'b1;
    tick();
    post("done_wait_state", {60'd0, CurState}, 64'd14);
    post("done_low_in_wait", {63'd0, Done}, 64'd0);
    tick();
    post("done_wait_holds", {60'd0, CurState}, 64'd14);
    Go = 1'b0;
    tick();
    post("back_to_load_a", {60'd0, CurState}, 64'd0);
    post("result_kept_27", {40'd0, Result}, 64'd27);

    run(8'd255, 8'd255, 8'd255, 8'd255, 64'hFE01FF, 64'd27);
    ack_done();

    run(8'd7, 8'd9, 8'd200, 8'd0, 64'd200, 64'hFE01FF);
    ack_done();

    // Go held for 10 cycles in LOAD_A while DataIn keeps changing
    sb.push_back(64'd50);
    DataIn = 8'd5;
    Go     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      DataIn = 8'(6 + i);
    end
    post("held_go_wait_state", {60'd0, CurState}, 64'd1);
    Go = 1'b0;
    tick();
    post("release_to_load_b", {60'd0, CurState}, 64'd2);
    load_op(8'd1, 3, 2);
    load_op(8'd2, 3, 2);
    load_op(8'd3, 3, 2);
    wait_done();
    ack_done();

    // Reset in the middle of computing
    load_op(8'd1, 3, 2);
    load_op(8'd2, 3, 2);
    load_op(8'd3, 3, 2);
    load_op(8'd4, 3, 2);
    wait_state(4'd10);
    post("result_held_c2", {40'd0, Result}, 64'd50);
    Reset = 1'b1;
    tick();
    post("abort_state", {60'd0, CurState}, 64'd0);
    post("abort_result", {40'd0, Result}, 64'd0);
    post("abort_done", {63'd0, Done}, 64'd0);
    post("abort_busy", {63'd0, Busy}, 64'd0);
    Reset = 1'b0;
    tick();

    run(8'd2, 8'd3, 8'd4, 8'd5, 64'd69, 64'd0);
    ack_done();

    end_req = 1'b1;
  end

  // Monitor: drains posted checks, scores each completed result, and
  // measures latency and Busy width from entry into C0
  initial begin
    logic [3:0]  prev_state;
    bit          prev_done;
    int          lat;
    int          busy_cnt;
    chk_t        c;
    logic [63:0] e;
    prev_state = 4'd0;
    prev_done  = 1'b0;
    lat        = 0;
    busy_cnt   = 0;
    forever begin
      @(negedge Clock);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_cmp++;
        if (c.act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d required %0d", c.name, c.act, c.exp);
        end
      end
      if (CurState == 4'd8 && prev_state != 4'd8) begin
        lat      = 0;
        busy_cnt = 0;
      end else begin
        lat++;
      end
      if (Busy) busy_cnt++;
      if (Done && !prev_done) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL result_unexpected: got %0d required none", Result);
        end else begin
          e = sb.pop_front();
          if ({40'd0, Result} !== e) begin
            n_bad++;
            $display("FAIL result: got %0d required %0d", Result, e);
          end
        end
        n_cmp++;
        if (lat != 5) begin
          n_bad++;
          $display("FAIL done_latency: got %0d required 5", lat);
        end
        n_cmp++;
        if (busy_cnt != 5) begin
          n_bad++;
          $display("FAIL busy_cycles: got %0d required 5", busy_cnt);
        end
        n_cmp++;
        if (Busy !== 1'b0) begin
          n_bad++;
          $display("FAIL busy_with_done: got %0d required 0", Busy);
        end
      end
      prev_state = CurState;
      prev_done  = Done;
      if (end_req && chk_q.size() == 0) begin
        n_cmp++;
        if (sb.size() != 0) begin
          n_bad++;
          $display("FAIL results_outstanding: got %0d required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
